// File: rtl/alu_ctrl_seq_if.sv
// rtl/alu_ctrl_seq_if.sv - request/result handshake bundle for alu_ctrl_seq
interface alu_ctrl_seq_if #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        aluop;
  logic [FUNC_W-1:0] func;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic [3:0]        aluc;
  logic              illegal;
  logic              busy;

  modport master (
    output in_valid, aluop, func, a, b, out_ready,
    input  in_ready, out_valid, result, zero, aluc, illegal, busy
  );

  modport slave (
    input  in_valid, aluop, func, a, b, out_ready,
    output in_ready, out_valid, result, zero, aluc, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control decode plus execute stage with valid/ready handshake
// SHIFT_BARREL_EN: single-cycle barrel shifts instead of the 1-bit/cycle iterative shifter.
module alu_ctrl_seq #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
) (
  input logic          clk,
  input logic          rst,
  alu_ctrl_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_XOR = 4'b0011;
  localparam logic [3:0] ALUC_NOR = 4'b0100;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;
  localparam logic [3:0] ALUC_SLL = 4'b1000;
  localparam logic [3:0] ALUC_SRL = 4'b1001;
  localparam logic [3:0] ALUC_ILL = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [3:0]       aluc_q, aluc_d;
  logic             illegal_q, illegal_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [3:0]       dec_aluc;
  logic             dec_illegal;
  logic [WIDTH-1:0] exec_res;
  logic             exec_multi;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] step_res;
  logic             accept;

  assign shamt  = bus.b[SHW-1:0];
  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    dec_aluc    = ALUC_ADD;
    dec_illegal = 1'b0;
    case (bus.aluop)
      2'b00: dec_aluc = ALUC_ADD;
      2'b01,
      2'b11: dec_aluc = ALUC_SUB;
      default: begin
        if (|bus.func[FUNC_W-1:4]) begin
          dec_aluc    = ALUC_ILL;
          dec_illegal = 1'b1;
        end else begin
          case (bus.func[3:0])
            4'b0000: dec_aluc = ALUC_ADD;
            4'b0010: dec_aluc = ALUC_SUB;
            4'b0100: dec_aluc = ALUC_AND;
            4'b0101: dec_aluc = ALUC_OR;
            4'b1010: dec_aluc = ALUC_SLT;
            4'b0110: dec_aluc = ALUC_XOR;
            4'b0111: dec_aluc = ALUC_NOR;
            4'b1000: dec_aluc = ALUC_SLL;
            4'b1001: dec_aluc = ALUC_SRL;
            default: begin
              dec_aluc    = ALUC_ILL;
              dec_illegal = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    exec_res   = '0;
    exec_multi = 1'b0;
    case (dec_aluc)
      ALUC_ADD: exec_res = bus.a + bus.b;
      ALUC_SUB: exec_res = bus.a - bus.b;
      ALUC_AND: exec_res = bus.a & bus.b;
      ALUC_OR:  exec_res = bus.a | bus.b;
      ALUC_XOR: exec_res = bus.a ^ bus.b;
      ALUC_NOR: exec_res = ~(bus.a | bus.b);
      ALUC_SLT: exec_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
`ifdef SHIFT_BARREL_EN
      ALUC_SLL: exec_res = bus.a << shamt;
      ALUC_SRL: exec_res = bus.a >> shamt;
`else
      // Iterative shifts start from the unshifted operand; amount 0 finishes immediately.
      ALUC_SLL,
      ALUC_SRL: begin
        exec_res   = bus.a;
        exec_multi = (shamt != '0);
      end
`endif
      default:  exec_res = '0;
    endcase
  end

  assign step_res = (aluc_q == ALUC_SLL) ? (result_q << 1) : (result_q >> 1);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    aluc_d    = aluc_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      SHIFT: begin
        result_d = step_res;
        zero_d   = (step_res == '0);
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready && !accept) state_d = IDLE;
      end
      default: state_d = state_q;
    endcase
    if (accept) begin
      result_d  = exec_res;
      zero_d    = (exec_res == '0);
      aluc_d    = dec_aluc;
      illegal_d = dec_illegal;
      cnt_d     = shamt;
      state_d   = exec_multi ? SHIFT : DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      aluc_q    <= 4'b0000;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      aluc_q    <= aluc_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.aluc      = aluc_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed-vector bench for alu_ctrl_seq
module tb_alu_ctrl_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.WIDTH(32), .FUNC_W(6)) bus ();
  alu_ctrl_seq #(.WIDTH(32), .FUNC_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
    bus.aluop = op; bus.func = fn; bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    vectors++; if (bus.aluc !== 4'b0000) begin miscompares++; $display("FAIL reset_aluc got %b exp 0000", bus.aluc); end
    vectors++; if (bus.result !== 32'd0) begin miscompares++; $display("FAIL reset_result got %h exp 0", bus.result); end
    vectors++; if ({bus.zero, bus.illegal, bus.busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b exp 000", {bus.zero, bus.illegal, bus.busy}); end
  endtask

  task automatic test_one_cycle_ops;
    logic [1:0]  op[7]   = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
    logic [5:0]  fn[7]   = '{6'h00, 6'h00, 6'h0A, 6'h04, 6'h07, 6'h00, 6'h3F};
    logic [31:0] av[7]   = '{32'd5, 32'd9, 32'hFFFF_FFFF, 32'h0000_F0F0, 32'd0, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] bv[7]   = '{32'd7, 32'd9, 32'd1, 32'h0000_FF00, 32'd0, 32'd5, 32'd2};
    logic [31:0] er[7]   = '{32'd12, 32'd0, 32'd1, 32'h0000_F000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    logic [3:0]  ea[7]   = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0100, 4'b0110, 4'b0010};
    for (int i = 0; i < 7; i++) begin
      send(op[i], fn[i], av[i], bv[i]);
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL op%0d_out_valid got %b exp 1", i, bus.out_valid); end
      vectors++; if (bus.result !== er[i]) begin miscompares++; $display("FAIL op%0d_result got %h exp %h", i, bus.result, er[i]); end
      vectors++; if (bus.aluc !== ea[i]) begin miscompares++; $display("FAIL op%0d_aluc got %b exp %b", i, bus.aluc, ea[i]); end
      vectors++; if (bus.zero !== (er[i] == 32'd0)) begin miscompares++; $display("FAIL op%0d_zero got %b exp %b", i, bus.zero, er[i] == 32'd0); end
      vectors++; if (bus.illegal !== 1'b0) begin miscompares++; $display("FAIL op%0d_illegal got %b exp 0", i, bus.illegal); end
      drain();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL op%0d_drain got %b exp 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_illegal;
    logic [5:0] fn[3] = '{6'b001011, 6'b010000, 6'b000001};
    for (int i = 0; i < 3; i++) begin
      send(2'b10, fn[i], 32'd123, 32'd456);
      vectors++; if ({bus.out_valid, bus.illegal, bus.zero} !== 3'b111) begin miscompares++; $display("FAIL ill%0d_flags got %b exp 111", i, {bus.out_valid, bus.illegal, bus.zero}); end
      vectors++; if (bus.aluc !== 4'b1111) begin miscompares++; $display("FAIL ill%0d_aluc got %b exp 1111", i, bus.aluc); end
      vectors++; if (bus.result !== 32'd0) begin miscompares++; $display("FAIL ill%0d_result got %h exp 0", i, bus.result); end
      drain();
    end
  endtask

  task automatic test_sll;
    send(2'b10, 6'b001000, 32'd1, 32'd4);
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b100) begin miscompares++; $display("FAIL sll_cyc%0d got %b exp 100", i, {bus.busy, bus.in_ready, bus.out_valid}); end
      step();
    end
    vectors++; if ({bus.busy, bus.out_valid} !== 2'b01) begin miscompares++; $display("FAIL sll_done got %b exp 01", {bus.busy, bus.out_valid}); end
    vectors++; if (bus.result !== 32'd16) begin miscompares++; $display("FAIL sll_result got %h exp 10", bus.result); end
    vectors++; if (bus.aluc !== 4'b1000) begin miscompares++; $display("FAIL sll_aluc got %b exp 1000", bus.aluc); end
    drain();
  endtask

  task automatic test_shift_bounds;
    int n;
    // amount 0 (b[4:0]=0, upper b bits ignored): single-cycle, value passes through
    send(2'b10, 6'b001000, 32'd3, 32'd32);
    vectors++; if ({bus.out_valid, bus.busy} !== 2'b10) begin miscompares++; $display("FAIL sh0_state got %b exp 10", {bus.out_valid, bus.busy}); end
    vectors++; if (bus.result !== 32'd3) begin miscompares++; $display("FAIL sh0_result got %h exp 3", bus.result); end
    drain();
    // SRL by max amount 31, b upper bits set
    send(2'b10, 6'b001001, 32'h8000_0000, 32'h0000_01FF);
    n = 0;
    while (!bus.out_valid && n < 40) begin step(); n++; end
    vectors++; if (n !== 31) begin miscompares++; $display("FAIL srl_cycles got %0d exp 31", n); end
    vectors++; if (bus.result !== 32'd1) begin miscompares++; $display("FAIL srl_result got %h exp 1", bus.result); end
    vectors++; if (bus.aluc !== 4'b1001) begin miscompares++; $display("FAIL srl_aluc got %b exp 1001", bus.aluc); end
    drain();
  endtask

  task automatic test_back_to_back;
    send(2'b00, 6'h00, 32'd1, 32'd2);
    bus.aluop = 2'b00; bus.func = 6'h00; bus.a = 32'd10; bus.b = 32'd20; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin miscompares++; $display("FAIL hold%0d_hs got %b exp 10", i, {bus.out_valid, bus.in_ready}); end
      vectors++; if (bus.result !== 32'd3) begin miscompares++; $display("FAIL hold%0d_result got %h exp 3", i, bus.result); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got %b exp 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    vectors++; if ({bus.out_valid, bus.result} !== {1'b1, 32'd30}) begin miscompares++; $display("FAIL b2b_result got %b/%h exp 1/1e", bus.out_valid, bus.result); end
    step();
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b exp 0", bus.out_valid); end
    // in_valid held low and out_ready idle: nothing happens
    bus.out_ready = 1'b1;
    step(); step();
    bus.out_ready = 1'b0;
    vectors++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin miscompares++; $display("FAIL idle_ignore got %b exp 01", {bus.out_valid, bus.in_ready}); end
  endtask

  task automatic test_rst_mid_shift;
    send(2'b10, 6'b001000, 32'd1, 32'd8);
    step();
    rst = 1'b1;
    #1;
    vectors++; if ({bus.out_valid, bus.busy} !== 2'b00) begin miscompares++; $display("FAIL rst_mid_state got %b exp 00", {bus.out_valid, bus.busy}); end
    vectors++; if (bus.result !== 32'd0) begin miscompares++; $display("FAIL rst_mid_result got %h exp 0", bus.result); end
    step();
    rst = 1'b0;
    step();
    vectors++; if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin miscompares++; $display("FAIL rst_release got %b exp 100", {bus.in_ready, bus.out_valid, bus.busy}); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.aluop = 2'b00; bus.func = '0; bus.a = '0; bus.b = '0;
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_one_cycle_ops();
    test_illegal();
    test_sll();
    test_shift_bounds();
    test_back_to_back();
    test_rst_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
